// File: rtl/pipeline_types_pkg.sv
// Shared pipeline types: register/word widths, latch stall codes, control FSM
// states and PC source selects.
package pipeline_types_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned REG_W  = 5;

    typedef logic [REG_W-1:0]  regbits_t;
    typedef logic [WORD_W-1:0] word_t;

    // One-hot latch control; the set bit names the deepest latch that holds
    typedef enum logic [4:0] {
        noStall    = 5'b00001,
        ifidStall  = 5'b00010,
        idexStall  = 5'b00100,
        exmemStall = 5'b01000,
        allStall   = 5'b10000
    } pStall_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } ctrl_state_t;

    typedef enum logic [1:0] {
        PCSEL_PC4    = 2'd0,
        PCSEL_JUMP   = 2'd1,
        PCSEL_BRANCH = 2'd2
    } pcsel_t;

endpackage

// File: rtl/sat_counter.sv
// 32-bit event counter that sticks at all-ones; asynchronous clear.
module sat_counter
    import pipeline_types_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  en_i,
    output word_t cnt_o
);

    word_t cnt_q;
    word_t cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + WORD_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/stall scheduler for the 5-stage pipeline: latch hold/bubble control,
// PC enable/redirect, halt drain-down and cycle/stall performance counters.
module pipeline_ctrl
    import pipeline_types_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       ihit,
    input  logic       dhit,
    input  logic       exmem_dMemRead,
    input  logic       exmem_dMemWrite,
    input  logic       idex_dMemRead,
    input  regbits_t   idex_rt,
    input  regbits_t   ifid_rs,
    input  regbits_t   ifid_rt,
    input  logic       idex_halt,
    input  logic       memwb_halt,
    input  logic       jump_id,
    input  logic       branch_taken,
    output pStall_t    stall,
    output logic       pc_en,
    output logic [1:0] pc_redirect,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       exmem_flush,
    output logic       halt,
    output word_t      cyc_cnt,
    output word_t      stall_cnt
);

    ctrl_state_t state_q;
    ctrl_state_t state_d;
    pcsel_t      pcsel_c;
    logic        dwait_c;
    logic        loaduse_c;

    assign dwait_c   = (exmem_dMemRead | exmem_dMemWrite) & ~dhit;
    assign loaduse_c = idex_dMemRead & (idex_rt != '0)
                     & ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Fixed-priority latch/PC control plus halt sequencing
    always_comb begin
        state_d     = state_q;
        stall       = noStall;
        pc_en       = 1'b0;
        pcsel_c     = PCSEL_PC4;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;

        if (state_q == HALTED) begin
            stall = allStall;
        end else if (dwait_c) begin
            stall = exmemStall;
        end else if (branch_taken) begin
            pc_en       = 1'b1;
            pcsel_c     = PCSEL_BRANCH;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (state_q == DRAIN) begin
            ifid_flush = 1'b1;
        end else if (loaduse_c) begin
            stall = ifidStall;
        end else if (jump_id) begin
            pc_en      = 1'b1;
            pcsel_c    = PCSEL_JUMP;
            ifid_flush = 1'b1;
        end else if (!ihit) begin
            ifid_flush = 1'b1;
        end else begin
            pc_en = 1'b1;
        end

        // A halt squashed by a taken branch was on the wrong path
        case (state_q)
            RUN:     if (idex_halt && !branch_taken && !dwait_c) state_d = DRAIN;
            DRAIN:   if (memwb_halt && !dwait_c) state_d = HALTED;
            default: state_d = state_q;
        endcase
    end

    assign pc_redirect = pcsel_c;
    assign halt        = (state_q == HALTED);

    sat_counter u_cyc_cnt (
        .clk   (CLK),
        .rst   (RST),
        .en_i  (state_q != HALTED),
        .cnt_o (cyc_cnt)
    );

    sat_counter u_stall_cnt (
        .clk   (CLK),
        .rst   (RST),
        .en_i  ((state_q == RUN) && !pc_en),
        .cnt_o (stall_cnt)
    );

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard and stall scheduler for the 5-stage pipeline; sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB latches and decides every cycle which latches hold, which take a bubble and whether the PC advances or is redirected. Resolves imem/dmem wait, load-use, taken branch and jump redirects, and sequences halt drain-down. Also keeps cycle and stall performance counters.

## Interface
- No parameters.
- CLK  in  1  pipeline clock
- RST  in  1  asynchronous, active-high reset
- ihit  in  1  icache returned valid instruction this cycle
- dhit  in  1  dcache completed the EX/MEM access this cycle
- exmem_dMemRead, exmem_dMemWrite  in  1 each  memory op in MEM stage
- idex_dMemRead  in  1  load in EX stage
- idex_rt  in  regbits_t  load destination
- ifid_rs, ifid_rt  in  regbits_t  sources of the instruction in ID
- idex_halt  in  1  halt in EX stage
- memwb_halt  in  1  halt in WB stage
- jump_id  in  1  jump/jr resolved in ID
- branch_taken  in  1  branch resolved taken in MEM stage
- stall  out  pStall_t  one-hot latch control
- pc_en  out  1  PC loads next value
- pc_redirect  out  2  0 = pc4, 1 = jump target, 2 = branch target
- ifid_flush, idex_flush, exmem_flush  out  1  latch loads a bubble
- halt  out  1  processor halted
- cyc_cnt, stall_cnt  out  word_t  performance counters

## Operation
- States: RUN, DRAIN, HALTED. Reset -> RUN.
- dwait = (exmem_dMemRead | exmem_dMemWrite) & !dhit.
- loaduse = idex_dMemRead & idex_rt != 0 & (idex_rt == ifid_rs | idex_rt == ifid_rt).
- Priority (highest first), evaluated combinationally every cycle:
  - HALTED: stall = allStall, pc_en = 0, all flushes 0.
  - dwait: stall = exmemStall (PC, IF/ID, ID/EX, EX/MEM hold; MEM/WB bubble); pc_en = 0; flushes 0.
  - branch_taken: stall = noStall, pc_en = 1, pc_redirect = 2, ifid/idex/exmem_flush = 1.
  - DRAIN: stall = noStall, pc_en = 0, ifid_flush = 1.
  - loaduse: stall = ifidStall (PC, IF/ID hold; ID/EX bubble); pc_en = 0.
  - jump_id: pc_en = 1, pc_redirect = 1, ifid_flush = 1.
  - !ihit: stall = noStall, pc_en = 0, ifid_flush = 1.
  - else noStall, pc_en = 1, pc_redirect = 0, no flush.
- Redirect loads the PC regardless of ihit; the outstanding fetch is discarded.
- idexStall is reserved; never asserted. stall always exactly one-hot.
- Transitions: RUN -> DRAIN when idex_halt & !branch_taken & !dwait (a halt on a flushed wrong path is ignored). DRAIN -> HALTED when memwb_halt & !dwait. HALTED exits only on RST.
- halt = (state == HALTED).
- cyc_cnt: +1 every cycle state != HALTED. stall_cnt: +1 every cycle state == RUN & pc_en == 0. Both saturate at 0xFFFFFFFF.

## Timing
- All control outputs combinational from current state and inputs (zero latency); state and counters update on CLK rising edge.
- RST asserted: state = RUN, cyc_cnt = stall_cnt = 0 immediately; halt = 0. With all inputs 0 after reset: stall = noStall, pc_en = 0, ifid_flush = 1 (no ihit).
- Load-use costs exactly one bubble: next cycle the load is in MEM, loaduse deasserts.
- Branch penalty 3 bubbles; jump penalty 1.
- Simultaneous dwait and branch_taken is illegal (same slot); dwait wins.
- RST mid-DRAIN or mid-dwait returns to RUN with counters cleared in the same cycle.

## Structure
- Add ctrl_state_t enum (RUN, DRAIN, HALTED) and pcsel_t (PCSEL_PC4, PCSEL_JUMP, PCSEL_BRANCH) to pipeline_types_pkg; pStall_t reused as is.
- Single module; the two saturating counters may be one sub-module sat_counter (32-bit, enable, async clear).

## Test plan
- Load to $t0 in EX, ID reads $t0 as rs -> one cycle stall = ifidStall, idex_flush-equivalent bubble, pc_en = 0; next cycle noStall; stall_cnt = 1.
- Same with idex_rt = 0 -> no stall.
- exmem_dMemRead with dhit low 4 cycles -> exmemStall for 4 cycles, pc_en = 0, then noStall on dhit.
- branch_taken with ihit = 0 -> pc_en = 1, pc_redirect = 2, three flushes asserted same cycle.
- idex_halt, memwb_halt two cycles later -> DRAIN for 2 cycles with ifid_flush = 1, then halt = 1, stall = allStall, cyc_cnt frozen.
- idex_halt and branch_taken together -> remains RUN; assert RST during DRAIN -> RUN, counters 0.
